rst_seq_ctrl: RTL and testbench



---
 rtl/rst_seq_if.sv | 27 ++
 rtl/rst_seq_ctrl.sv | 163 ++++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rst_seq_if.sv
// Soft-reset request bus and per-channel reset outputs of rst_seq_ctrl.
// The requester owns the master modport; the sequencer owns the slave modport.
interface rst_seq_if #(
  parameter int CH_NUM = 4
);
  logic              req_i;
  logic [CH_NUM-1:0] chan_mask_i;
  logic [CH_NUM-1:0] rst_n_o;
  logic              busy_o;
  logic              done_o;

  modport master (
    output req_i,
    output chan_mask_i,
    input  rst_n_o,
    input  busy_o,
    input  done_o
  );

  modport slave (
    input  req_i,
    input  chan_mask_i,
    output rst_n_o,
    output busy_o,
    output done_o
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds CH_NUM active-low resets for HOLD_CYC, then releases them in index order GAP_CYC apart.
// Macro RST_SEQ_SYNC_IN_EN inserts a two-flop synchronizer on req_i/chan_mask_i (2 cycles extra latency).
module rst_seq_ctrl #(
  parameter int CH_NUM   = 4,
  parameter int HOLD_CYC = 16,
  parameter int GAP_CYC  = 8
) (
  input  logic       clk,
  input  logic       rst_i,
  rst_seq_if.slave   bus,
  output logic [1:0] dbg_state_o
);
  localparam int CNT_MAX = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [IDX_W:0]   ONE_IDX   = (IDX_W + 1)'(1);

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_REL  = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH_NUM-1:0] act_q, act_d;
  logic [CH_NUM-1:0] rst_n_q, rst_n_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              req_eff;
  logic [CH_NUM-1:0] mask_eff;
  logic [IDX_W:0]    search_lo;
  logic [IDX_W:0]    cand;
  logic [IDX_W:0]    more;

  // Request protocol: req_i is a level sampled on every edge; there is no ready.
  // It is accepted only while busy_o is low and chan_mask_i is non-zero; otherwise it is dropped, never queued.
`ifdef RST_SEQ_SYNC_IN_EN
  logic              s1_req_q, s1_req_d, s2_req_q, s2_req_d;
  logic [CH_NUM-1:0] s1_mask_q, s1_mask_d, s2_mask_q, s2_mask_d;

  always_comb begin
    s1_req_d  = bus.req_i;
    s1_mask_d = bus.chan_mask_i;
    s2_req_d  = s1_req_q;
    s2_mask_d = s1_mask_q;
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      s1_req_q  <= 1'b0;
      s1_mask_q <= '0;
      s2_req_q  <= 1'b0;
      s2_mask_q <= '0;
    end else begin
      s1_req_q  <= s1_req_d;
      s1_mask_q <= s1_mask_d;
      s2_req_q  <= s2_req_d;
      s2_mask_q <= s2_mask_d;
    end
  end

  assign req_eff  = s2_req_q;
  assign mask_eff = s2_mask_q;
`else
  assign req_eff  = bus.req_i;
  assign mask_eff = bus.chan_mask_i;
`endif

  // Returns {found, index} of the lowest set bit of m at or above lo.
  function automatic logic [IDX_W:0] find_set(input logic [CH_NUM-1:0] m,
                                              input logic [IDX_W:0]  lo);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (m[i] && (i >= int'(lo))) r = {1'b1, IDX_W'(i)};
    end
    return r;
  endfunction

  always_comb begin
    search_lo = (state_q == S_HOLD) ? '0 : ({1'b0, idx_q} + ONE_IDX);
    cand      = find_set(act_q, search_lo);
    more      = find_set(act_q, {1'b0, cand[IDX_W-1:0]} + ONE_IDX);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_HOLD, S_REL: begin
        cnt_d = cnt_q + 1'b1;
        if (((state_q == S_HOLD) && (cnt_q == HOLD_LAST)) ||
            ((state_q == S_REL)  && (cnt_q == GAP_LAST))) begin
          cnt_d = '0;
          if (cand[IDX_W]) begin
            rst_n_d[cand[IDX_W-1:0]] = 1'b1;
            idx_d                    = cand[IDX_W-1:0];
          end
          // The highest active channel closes the sequence on its own release edge.
          if (!more[IDX_W]) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_RUN;
          end else begin
            state_d = S_REL;
          end
        end
      end
      S_RUN: begin
        if (req_eff && (mask_eff != '0)) begin
          act_d   = mask_eff;
          rst_n_d = rst_n_q & ~mask_eff;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_HOLD;
        cnt_d   = '0;
        act_d   = '1;
        rst_n_d = '0;
        busy_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      act_q   <= '1;
      idx_q   <= '0;
      rst_n_q <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.rst_n_o  = rst_n_q;
  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: timing tables for power-on and soft reset, hand-written corner sequences,
// then random stimulus checked against a release-schedule model.
module tb_rst_seq_ctrl;
  localparam int CH   = 4;
  localparam int HOLD = 16;
  localparam int GAP  = 8;
  localparam int W    = CH + 2;
`ifdef RST_SEQ_SYNC_IN_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk   = 1'b0;
  logic       rst_i = 1'b1;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  rst_seq_if #(.CH_NUM(CH)) bus ();

  rst_seq_ctrl #(
    .CH_NUM  (CH),
    .HOLD_CYC(HOLD),
    .GAP_CYC (GAP)
  ) dut (
    .clk        (clk),
    .rst_i      (rst_i),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            k;
    logic [CH-1:0] rst_n;
    logic          busy;
    logic          done;
  } vec_t;

  vec_t pon_tab[$];
  vec_t soft_tab[$];

  task automatic check(input string name, input int k, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s k=%0d got=%b expected=%b", name, k, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input int k, input vec_t v);
    check({name, "_rst_n"}, k, W'(bus.rst_n_o), W'(v.rst_n));
    check({name, "_busy"},  k, W'(bus.busy_o),  W'(v.busy));
    check({name, "_done"},  k, W'(bus.done_o),  W'(v.done));
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    @(negedge clk);
    rst_i           = 1'b1;
    bus.req_i       = 1'b0;
    bus.chan_mask_i = '0;
    repeat (n) @(negedge clk);
    check("reset_rst_n", 0, W'(bus.rst_n_o), W'(4'b0000));
    check("reset_busy",  0, W'(bus.busy_o),  W'(1'b1));
    check("reset_done",  0, W'(bus.done_o),  W'(1'b0));
    rst_i = 1'b0;
  endtask

  // Walks edges E0..E0+40 after a released reset; optionally pokes an ignored request mid-release.
  task automatic pon_seq(input bit with_req);
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      foreach (pon_tab[i]) if (pon_tab[i].k == k) check_vec("pon", k, pon_tab[i]);
      if (with_req) begin
        bus.req_i       = (k >= 18 && k < 28);
        bus.chan_mask_i = 4'b1111;
      end
    end
    bus.req_i       = 1'b0;
    bus.chan_mask_i = '0;
  endtask

  task automatic soft_seq();
    bus.req_i       = 1'b1;
    bus.chan_mask_i = 4'b1010;
    for (int j = 0; j <= 26 + LAT; j++) begin
      @(negedge clk);
      bus.req_i       = 1'b0;
      bus.chan_mask_i = '0;
      foreach (soft_tab[i]) if (soft_tab[i].k == j) check_vec("soft", j, soft_tab[i]);
      check("soft_keep02", j, W'({bus.rst_n_o[2], bus.rst_n_o[0]}), W'(2'b11));
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0]  exp_q[$];
  bit            rnd_on = 1'b0;
  longint        cyc    = 0;
  longint        rel_at[CH];
  longint        end_at = -1;
  logic [CH-1:0] m_rst_n = '0;
  logic          m_busy  = 1'b1;
  logic          m_done  = 1'b0;
  logic          p1_req  = 1'b0, p2_req = 1'b0;
  logic [CH-1:0] p1_mask = '0,   p2_mask = '0;
  logic          e_req;
  logic [CH-1:0] e_mask;

  // Each active channel gets an absolute release edge; the last one marks completion.
  task automatic schedule(input logic [CH-1:0] m);
    int n;
    n = 0;
    for (int c = 0; c < CH; c++) begin
      rel_at[c] = -1;
      if (m[c]) begin
        rel_at[c] = cyc + HOLD + n * GAP;
        n++;
      end
    end
    end_at = cyc + HOLD + (n - 1) * GAP;
  endtask

  always @(posedge clk) begin
    cyc++;
`ifdef RST_SEQ_SYNC_IN_EN
    e_req  = p2_req;
    e_mask = p2_mask;
`else
    e_req  = bus.req_i;
    e_mask = bus.chan_mask_i;
`endif
    m_done = 1'b0;
    if (rst_i) begin
      m_rst_n = '0;
      m_busy  = 1'b1;
      schedule('1);
      p1_req  = 1'b0;
      p2_req  = 1'b0;
      p1_mask = '0;
      p2_mask = '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (rel_at[c] == cyc) begin
          m_rst_n[c] = 1'b1;
          rel_at[c]  = -1;
        end
      end
      if (m_busy && end_at == cyc) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end else if (!m_busy && e_req && e_mask != '0) begin
        m_rst_n = m_rst_n & ~e_mask;
        m_busy  = 1'b1;
        schedule(e_mask);
      end
      p2_req  = p1_req;
      p2_mask = p1_mask;
      p1_req  = bus.req_i;
      p1_mask = bus.chan_mask_i;
    end
    if (rnd_on) exp_q.push_back({m_rst_n, m_busy, m_done});
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [W-1:0] e;
    bus.req_i       = 1'b0;
    bus.chan_mask_i = '0;

    pon_tab.push_back('{0,  4'b0000, 1'b1, 1'b0});
    pon_tab.push_back('{14, 4'b0000, 1'b1, 1'b0});
    pon_tab.push_back('{15, 4'b0001, 1'b1, 1'b0});
    pon_tab.push_back('{22, 4'b0001, 1'b1, 1'b0});
    pon_tab.push_back('{23, 4'b0011, 1'b1, 1'b0});
    pon_tab.push_back('{30, 4'b0011, 1'b1, 1'b0});
    pon_tab.push_back('{31, 4'b0111, 1'b1, 1'b0});
    pon_tab.push_back('{38, 4'b0111, 1'b1, 1'b0});
    pon_tab.push_back('{39, 4'b1111, 1'b0, 1'b1});
    pon_tab.push_back('{40, 4'b1111, 1'b0, 1'b0});

`ifdef RST_SEQ_SYNC_IN_EN
    soft_tab.push_back('{1, 4'b1111, 1'b0, 1'b0});
`endif
    soft_tab.push_back('{LAT + 0,  4'b0101, 1'b1, 1'b0});
    soft_tab.push_back('{LAT + 15, 4'b0101, 1'b1, 1'b0});
    soft_tab.push_back('{LAT + 16, 4'b0111, 1'b1, 1'b0});
    soft_tab.push_back('{LAT + 23, 4'b0111, 1'b1, 1'b0});
    soft_tab.push_back('{LAT + 24, 4'b1111, 1'b0, 1'b1});
    soft_tab.push_back('{LAT + 25, 4'b1111, 1'b0, 1'b0});

    // Power-on, then a 1010 soft reset.
    do_reset(5);
    pon_seq(1'b0);
    soft_seq();

    // Zero-mask request in S_RUN is ignored.
    bus.req_i       = 1'b1;
    bus.chan_mask_i = 4'b0000;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check("zero_mask_rst_n", j, W'(bus.rst_n_o), W'(4'b1111));
      check("zero_mask_busy",  j, W'(bus.busy_o),  W'(1'b0));
      check("zero_mask_done",  j, W'(bus.done_o),  W'(1'b0));
    end
    bus.req_i = 1'b0;

    // Request and reset on the same edge: reset wins, full power-on timing follows.
    @(negedge clk);
    rst_i           = 1'b1;
    bus.req_i       = 1'b1;
    bus.chan_mask_i = 4'b1111;
    @(negedge clk);
    rst_i           = 1'b0;
    bus.req_i       = 1'b0;
    bus.chan_mask_i = '0;
    check("simul_rst_n", 0, W'(bus.rst_n_o), W'(4'b0000));
    check("simul_busy",  0, W'(bus.busy_o),  W'(1'b1));
    pon_seq(1'b0);

    // Reset one edge after bit1 releases, then restart with an ignored request during S_REL.
    do_reset(5);
    for (int k = 0; k <= 23; k++) @(negedge clk);
    check("mid_pre_rst_n", 23, W'(bus.rst_n_o), W'(4'b0011));
    rst_i = 1'b1;
    @(negedge clk);
    check("mid_rst_n", 24, W'(bus.rst_n_o), W'(4'b0000));
    check("mid_busy",  24, W'(bus.busy_o),  W'(1'b1));
    check("mid_done",  24, W'(bus.done_o),  W'(1'b0));
    rst_i = 1'b0;
    pon_seq(1'b1);

    // Randomized run against the schedule model.
    rnd_on          = 1'b1;
    rst_i           = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rnd_queue k=%0d got=empty expected=entry", n);
      end else begin
        e = exp_q.pop_front();
        check("rnd", n, {bus.rst_n_o, bus.busy_o, bus.done_o}, e);
      end
      rst_i           = ($urandom_range(0, 299) == 0);
      bus.req_i       = ($urandom_range(0, 7) == 0);
      bus.chan_mask_i = CH'($urandom_range(0, (1 << CH) - 1));
    end
    rnd_on    = 1'b0;
    rst_i     = 1'b0;
    bus.req_i = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
